// File: rtl/lcd_defs.sv
// Shared definitions for the LCD text buffer: FSM states, control codes and
// the printable character window.
package lcd_defs;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_HOLD,
        ST_TRIG,
        ST_WAIT_ACK,
        ST_WAIT_DONE
    } state_t;

    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_SPACE = 8'h20;

    localparam logic [7:0] CH_PRINT_LO = 8'h20;
    localparam logic [7:0] CH_PRINT_HI = 8'h7E;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= CH_PRINT_LO) && (c <= CH_PRINT_HI);
    endfunction

endpackage

// File: rtl/lcd_char_ram.sv
// Screen image storage: one synchronous write port, one combinational read
// port so the driver sees data in the same cycle it presents an address.
module lcd_char_ram #(
    parameter int MEM_DEPTH = 64,
    localparam int AW = $clog2(MEM_DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lcd_text_buffer.sv
// Character frame buffer in front of the HD44780 driver: accepts a character
// stream, keeps the screen image and batches writes into single refreshes.
module lcd_text_buffer
    import lcd_defs::*;
#(
    parameter int MEM_DEPTH   = 64,
    parameter int ROW_LEN     = 16,
    parameter int HOLDOFF     = 250,
    parameter int ACK_TIMEOUT = 16,
    localparam int AW = $clog2(MEM_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_char,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    input  logic          lcd_busy,
    output logic          lcd_trg,
    output logic [AW-1:0] cursor,
    output logic          dirty
);

    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam int TW = $clog2(ACK_TIMEOUT);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF - 1);
    localparam logic [TW-1:0] ACK_LOAD  = TW'(ACK_TIMEOUT - 1);
    localparam logic [AW-1:0] ROW_MASK  = AW'(ROW_LEN - 1);
    localparam logic [AW-1:0] LAST_IDX  = AW'(MEM_DEPTH - 1);

    state_t        state_reg, state_next;
    logic [AW-1:0] clr_idx_reg, clr_idx_next;
    logic [AW-1:0] cursor_reg, cursor_next;
    logic          dirty_reg, dirty_next;
    logic [HW-1:0] hold_cnt_reg, hold_cnt_next;
    logic [TW-1:0] ack_cnt_reg, ack_cnt_next;

    logic          accept, is_print, is_ctrl, set_dirty, ff_accept;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [7:0]    ram_wdata;

    assign in_ready  = (state_reg != ST_CLEAR);
    assign accept    = in_valid & in_ready;
    assign is_print  = is_printable(in_char);
    assign is_ctrl   = (in_char == CH_LF) || (in_char == CH_CR) ||
                       (in_char == CH_FF) || (in_char == CH_BS);
    assign set_dirty = accept & (is_print | is_ctrl);
    assign ff_accept = accept & (in_char == CH_FF);

    // Reset gates the pulse combinationally so an abort drops it immediately.
    assign lcd_trg = (state_reg == ST_TRIG) && !rst;
    assign cursor  = cursor_reg;
    assign dirty   = dirty_reg;

    always_comb begin
        state_next    = state_reg;
        clr_idx_next  = clr_idx_reg;
        cursor_next   = cursor_reg;
        dirty_next    = dirty_reg;
        hold_cnt_next = hold_cnt_reg;
        ack_cnt_next  = ack_cnt_reg;
        ram_we        = 1'b0;
        ram_waddr     = cursor_reg;
        ram_wdata     = in_char;

        if (accept) begin
            if (is_print) begin
                ram_we      = 1'b1;
                cursor_next = cursor_reg + 1'b1;
            end else if (in_char == CH_LF) begin
                cursor_next = (cursor_reg | ROW_MASK) + 1'b1;
            end else if (in_char == CH_CR) begin
                cursor_next = cursor_reg & ~ROW_MASK;
            end else if (in_char == CH_BS) begin
                cursor_next = cursor_reg - 1'b1;
            end
        end

        case (state_reg)
            ST_CLEAR: begin
                ram_we       = 1'b1;
                ram_waddr    = clr_idx_reg;
                ram_wdata    = CH_SPACE;
                clr_idx_next = clr_idx_reg + 1'b1;
                if (clr_idx_reg == LAST_IDX) begin
                    state_next  = ST_IDLE;
                    cursor_next = '0;
                    dirty_next  = 1'b1;
                end
            end
            ST_IDLE: begin
                // Counting from the accepting edge keeps the holdoff identical in IDLE and HOLD.
                if ((dirty_reg || set_dirty) && !lcd_busy) begin
                    state_next    = ST_HOLD;
                    hold_cnt_next = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (lcd_busy) begin
                    state_next = ST_IDLE;
                end else if (set_dirty) begin
                    hold_cnt_next = HOLD_LOAD;
                end else if (hold_cnt_reg == '0) begin
                    state_next = ST_TRIG;
                end else begin
                    hold_cnt_next = hold_cnt_reg - 1'b1;
                end
            end
            ST_TRIG: begin
                dirty_next   = 1'b0;
                state_next   = ST_WAIT_ACK;
                ack_cnt_next = ACK_LOAD;
            end
            ST_WAIT_ACK: begin
                if (lcd_busy) begin
                    state_next = ST_WAIT_DONE;
                end else if (ack_cnt_reg == '0) begin
                    state_next = ST_IDLE;
                    dirty_next = 1'b1;
                end else begin
                    ack_cnt_next = ack_cnt_reg - 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!lcd_busy) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_CLEAR;
        endcase

        // A fresh write always beats the TRIG-cycle clear.
        if (set_dirty) begin
            dirty_next = 1'b1;
        end
        if (ff_accept) begin
            state_next   = ST_CLEAR;
            clr_idx_next = '0;
            cursor_next  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_CLEAR;
            clr_idx_reg  <= '0;
            cursor_reg   <= '0;
            dirty_reg    <= 1'b1;
            hold_cnt_reg <= '0;
            ack_cnt_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            clr_idx_reg  <= clr_idx_next;
            cursor_reg   <= cursor_next;
            dirty_reg    <= dirty_next;
            hold_cnt_reg <= hold_cnt_next;
            ack_cnt_reg  <= ack_cnt_next;
        end
    end

    lcd_char_ram #(
        .MEM_DEPTH(MEM_DEPTH)
    ) u_ram (
        .clk    (clk),
        .we     (ram_we),
        .wr_addr(ram_waddr),
        .wr_data(ram_wdata),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

endmodule

// File: tb/tb_lcd_text_buffer.sv
// Bench for lcd_text_buffer: table-driven cursor vectors, random streams
// against a screen-image model, and hand-timed refresh/clear sequences.
module tb_lcd_text_buffer;

    localparam int MEM_DEPTH   = 64;
    localparam int ROW_LEN     = 16;
    localparam int HOLDOFF     = 250;
    localparam int ACK_TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_char;
    logic [5:0] rd_addr;
    logic [7:0] rd_data;
    logic       lcd_busy;
    logic       lcd_trg;
    logic [5:0] cursor;
    logic       dirty;

    lcd_text_buffer #(
        .MEM_DEPTH(MEM_DEPTH), .ROW_LEN(ROW_LEN),
        .HOLDOFF(HOLDOFF), .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_char(in_char), .rd_addr(rd_addr), .rd_data(rd_data),
        .lcd_busy(lcd_busy), .lcd_trg(lcd_trg), .cursor(cursor), .dirty(dirty)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int trg_count = 0;
    int last_trg_cyc = -1;
    int vectors = 0;
    int miscompares = 0;
    int tx_count = 0;

    // Behavioural screen model.
    int m_mem [MEM_DEPTH];
    int m_cur;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (lcd_trg === 1'b1) begin
            trg_count    = trg_count + 1;
            last_trg_cyc = cyc;
        end
    end

    typedef struct {
        logic [7:0] ch;
        int         exp_cursor;
        int         exp_dirty;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_apply(input logic [7:0] c);
        if (c >= 8'h20 && c <= 8'h7E) begin
            m_mem[m_cur] = int'(c);
            m_cur = (m_cur + 1) % MEM_DEPTH;
        end else if (c == 8'h0A) begin
            m_cur = ((m_cur / ROW_LEN + 1) * ROW_LEN) % MEM_DEPTH;
        end else if (c == 8'h0D) begin
            m_cur = (m_cur / ROW_LEN) * ROW_LEN;
        end else if (c == 8'h08) begin
            m_cur = (m_cur + MEM_DEPTH - 1) % MEM_DEPTH;
        end else if (c == 8'h0C) begin
            for (int i = 0; i < MEM_DEPTH; i++) m_mem[i] = 32'h20;
            m_cur = 0;
        end
    endtask

    task automatic send(input logic [7:0] c);
        int n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_ready) check("send_ready_timeout", 0, 1);
        in_valid = 1'b1;
        in_char  = c;
        tick();
        in_valid = 1'b0;
        model_apply(c);
        tx_count++;
        $display("tx %0d: char %02h at cycle %0d, cursor now %0d", tx_count, c, cyc, cursor);
    endtask

    task automatic read_check(input int a, input int exp, input string name);
        rd_addr = 6'(a);
        @(negedge clk);
        check(name, int'(rd_data), exp);
    endtask

    task automatic wait_trg(input int bound, input string name, output int t);
        int base = trg_count;
        int n = 0;
        while (trg_count == base && n < bound) begin
            tick();
            n++;
        end
        check(name, (trg_count > base) ? 1 : 0, 1);
        t = last_trg_cyc;
    endtask

    initial begin
        vec_t tbl [14];
        int   r, t, t2, s, k, n;
        logic [7:0] c;

        tbl[0]  = '{8'h01, 0,  0};
        tbl[1]  = '{8'h7F, 0,  0};
        tbl[2]  = '{8'h41, 1,  1};
        tbl[3]  = '{8'h42, 2,  1};
        tbl[4]  = '{8'h0A, 16, 1};
        tbl[5]  = '{8'h43, 17, 1};
        tbl[6]  = '{8'h0D, 16, 1};
        tbl[7]  = '{8'h08, 15, 1};
        tbl[8]  = '{8'h0A, 16, 1};
        tbl[9]  = '{8'h0A, 32, 1};
        tbl[10] = '{8'h0A, 48, 1};
        tbl[11] = '{8'h0A, 0,  1};
        tbl[12] = '{8'h08, 63, 1};
        tbl[13] = '{8'h5A, 0,  1};

        for (int i = 0; i < MEM_DEPTH; i++) m_mem[i] = 32'h20;
        m_cur    = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_char  = 8'h00;
        rd_addr  = '0;
        lcd_busy = 1'b0;

        // Reset values and the power-up clear.
        repeat (3) tick();
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_cursor", int'(cursor), 0);
        check("rst_dirty", int'(dirty), 1);
        check("rst_trg", int'(lcd_trg), 0);
        rst = 1'b0;
        r = cyc;
        repeat (63) tick();
        check("clear_ready_low_c63", int'(in_ready), 0);
        tick();
        check("clear_ready_high_c64", int'(in_ready), 1);
        check("clear_cursor", int'(cursor), 0);
        check("clear_dirty", int'(dirty), 1);
        for (int a = 0; a < MEM_DEPTH; a++) read_check(a, 32'h20, "clear_mem");
        wait_trg(400, "first_trg_seen", t);
        check("first_trg_cycle", t - r, HOLDOFF + 65);
        check("first_trg_count", trg_count, 1);
        check("trg_clears_dirty", int'(dirty), 0);
        lcd_busy = 1'b1;
        tick();

        // Table-driven cursor and dirty vectors.
        foreach (tbl[i]) begin
            send(tbl[i].ch);
            check($sformatf("tbl%0d_cursor", i), int'(cursor), tbl[i].exp_cursor);
            check($sformatf("tbl%0d_dirty", i), int'(dirty), tbl[i].exp_dirty);
        end
        read_check(0, 32'h41, "tbl_mem0");
        read_check(1, 32'h42, "tbl_mem1");
        read_check(16, 32'h43, "tbl_mem16");
        read_check(63, 32'h5A, "tbl_mem63");

        // Buffer wrap and backspace underflow.
        repeat (65) send(8'h58);
        check("wrap_cursor", int'(cursor), 1);
        read_check(0, 32'h58, "wrap_mem0");
        read_check(63, 32'h58, "wrap_mem63");
        send(8'h08);
        check("bs_to_zero", int'(cursor), 0);
        send(8'h08);
        check("bs_underflow", int'(cursor), 63);

        // Form feed, then a random stream against the model.
        send(8'h0C);
        check("ff_ready_low", int'(in_ready), 0);
        n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        check("ff_clear_len", n, MEM_DEPTH);
        check("ff_cursor", int'(cursor), 0);
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                6:       c = 8'h0A;
                7:       c = 8'h0D;
                8:       c = 8'h08;
                9:       c = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(127, 255))
                                                        : 8'($urandom_range(0, 7));
                default: c = 8'($urandom_range(32, 126));
            endcase
            send(c);
            check("rand_cursor", int'(cursor), m_cur);
            repeat ($urandom_range(0, 2)) tick();
        end
        for (int a = 0; a < MEM_DEPTH; a++) read_check(a, m_mem[a], "rand_mem");

        // Accepts every HOLDOFF-1 cycles keep postponing the trigger.
        lcd_busy = 1'b0;
        k = trg_count;
        for (int i = 0; i < 5; i++) begin
            send(8'h61);
            if (i < 4) repeat (HOLDOFF - 2) tick();
        end
        s = cyc;
        check("holdoff_no_trg", trg_count, k);
        wait_trg(HOLDOFF + 20, "holdoff_trg_seen", t);
        check("holdoff_trg_cycle", t - s, HOLDOFF);

        // No acknowledge: timeout, dirty forced, retrigger.
        check("ack_trg_dirty", int'(dirty), 0);
        repeat (ACK_TIMEOUT - 1) tick();
        check("ack_wait_dirty", int'(dirty), 0);
        tick();
        check("ack_timeout_dirty", int'(dirty), 1);
        wait_trg(HOLDOFF + 40, "retrig_seen", t2);
        check("retrig_cycle", t2 - t, ACK_TIMEOUT + HOLDOFF + 2);

        // Write during WAIT_DONE produces a second trigger.
        lcd_busy = 1'b1;
        tick();
        send(8'h71);
        check("wait_done_dirty", int'(dirty), 1);
        lcd_busy = 1'b0;
        s = cyc;
        wait_trg(HOLDOFF + 20, "wd_trg_seen", t);
        check("wd_trg_cycle", t - s, HOLDOFF + 2);

        // Form feed during WAIT_DONE: full clear, ends in IDLE.
        lcd_busy = 1'b1;
        tick();
        send(8'h0C);
        check("ff_wd_ready_low", int'(in_ready), 0);
        n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        check("ff_wd_clear_len", n, MEM_DEPTH);
        for (int a = 0; a < MEM_DEPTH; a++) read_check(a, m_mem[a], "ff_wd_mem");
        tick();
        lcd_busy = 1'b0;
        s = cyc;
        while (cyc < s + HOLDOFF + 1) tick();

        // Reset in the TRIG cycle drops the pulse at once.
        check("trg_before_rst", int'(lcd_trg), 1);
        rst = 1'b1;
        #1;
        check("rst_kills_trg", int'(lcd_trg), 0);
        tick();
        check("rst2_in_ready", int'(in_ready), 0);
        check("rst2_dirty", int'(dirty), 1);
        check("rst2_cursor", int'(cursor), 0);
        rst = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
